// File: rtl/fetch_queue.sv
// PC sequencer and length-tagged instruction queue between fetchbuffer and decode.
// Issues fetch requests, splits 16/32-bit instructions, and owns redirect/fence.i flushes.

package fetch_queue_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } fq_entry_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output mem_in_type  fetchbuffer_in,
  input  mem_out_type fetchbuffer_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        fence_req,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_instr,
  output logic        deq_comp
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, FLUSH, FENCE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  fq_entry_t          entries_q [QDEPTH];

  logic               flush;
  logic               enq;
  logic               deq_fire;
  logic               mem_valid;
  logic               mem_fence;
  logic               rcomp;
  fq_entry_t          new_entry;
  fq_entry_t          head;

  // Next-state, request and queue-control logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_valid = 1'b0;
    mem_fence = 1'b0;
    enq       = 1'b0;
    deq_fire  = 1'b0;

    flush = fence_req | redirect_valid;
    rcomp = (fetchbuffer_out.mem_rdata[1:0] != 2'b11);

    new_entry.pc    = pc_q;
    new_entry.instr = rcomp ? {16'h0000, fetchbuffer_out.mem_rdata[15:0]}
                            : fetchbuffer_out.mem_rdata;
    new_entry.comp  = rcomp;

    unique case (state_q)
      RUN:     mem_valid = (count_q < CNT_W'(QDEPTH));
      FLUSH:   state_d = RUN;
      FENCE: begin
        mem_valid = 1'b1;
        mem_fence = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase

    if (flush || rst) begin
      mem_valid = 1'b0;
      mem_fence = 1'b0;
    end

    deq_valid = (count_q != '0) & ~flush & ~rst;
    // Fence-cycle responses are ignored; only RUN accepts data
    enq      = (state_q == RUN) & mem_valid & fetchbuffer_out.mem_ready;
    deq_fire = deq_valid & deq_ready;

    if (enq) begin
      wptr_d = wptr_q + PTR_W'(1);
      pc_d   = pc_q + (rcomp ? 32'd2 : 32'd4);
    end
    if (deq_fire) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq_fire);

    if (flush) begin
      enq     = 1'b0;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      pc_d    = {redirect_addr[31:1], 1'b0};
      state_d = fence_req ? FENCE : FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Queue storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      entries_q[wptr_q] <= new_entry;
    end
  end

  always_comb begin
    head      = entries_q[rptr_q];
    deq_pc    = deq_valid ? head.pc    : 32'h0;
    deq_instr = deq_valid ? head.instr : 32'h0;
    deq_comp  = deq_valid ? head.comp  : 1'b0;

    fetchbuffer_in.mem_valid = mem_valid;
    fetchbuffer_in.mem_fence = mem_fence;
    fetchbuffer_in.mem_instr = 1'b1;
    fetchbuffer_in.mem_addr  = pc_q;
    fetchbuffer_in.mem_wdata = 32'h0;
    fetchbuffer_in.mem_wstrb = 4'h0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference of the fetch/dequeue rules.
// The bench plays fetchbuffer and decode; directed episodes anchor the key scenarios.

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned QD = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  mem_in_type  fb_in;
  mem_out_type fb_out;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        fence_req;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_comp;

  fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetchbuffer_in  (fb_in),
    .fetchbuffer_out (fb_out),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .fence_req       (fence_req),
    .deq_valid       (deq_valid),
    .deq_ready       (deq_ready),
    .deq_pc          (deq_pc),
    .deq_instr       (deq_instr),
    .deq_comp        (deq_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the fetched-but-undecoded instructions, the next fetch PC, and
  // whether the next cycle is a mandatory idle gap or the fence.i handshake.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } ref_entry_t;

  ref_entry_t  m_q[$];
  logic [31:0] m_pc = RPC;
  bit          m_idle_next  = 1'b0;
  bit          m_fence_next = 1'b0;

  task automatic step(input logic r, input logic f, input logic rv, input logic [31:0] ra,
                      input logic mr, input logic [31:0] rd, input logic dr);
    logic        e_mv, e_mf, e_dv, flush, comp, accept;
    logic [31:0] e_pc, e_in;
    logic        e_cp;
    ref_entry_t  e;
    @(negedge clk);
    rst = r; fence_req = f; redirect_valid = rv; redirect_addr = ra;
    fb_out.mem_ready = mr; fb_out.mem_rdata = rd; deq_ready = dr;
    #1;
    flush = f | rv;
    e_mv = 1'b0; e_mf = 1'b0; e_dv = 1'b0;
    e_pc = 32'h0; e_in = 32'h0; e_cp = 1'b0;
    if (!r) begin
      e_dv = (m_q.size() != 0) && !flush;
      if (e_dv) begin
        e_pc = m_q[0].pc; e_in = m_q[0].instr; e_cp = m_q[0].comp;
      end
      if (!flush) begin
        if (m_fence_next) begin
          e_mv = 1'b1; e_mf = 1'b1;
        end else if (!m_idle_next) begin
          e_mv = (m_q.size() < QD);
        end
      end
    end
    check("mem_valid", 32'(fb_in.mem_valid), 32'(e_mv));
    check("mem_fence", 32'(fb_in.mem_fence), 32'(e_mf));
    check("deq_valid", 32'(deq_valid), 32'(e_dv));
    check("deq_pc", deq_pc, e_pc);
    check("deq_instr", deq_instr, e_in);
    check("deq_comp", 32'(deq_comp), 32'(e_cp));
    check("mem_instr", 32'(fb_in.mem_instr), 32'h1);
    check("mem_wdata", fb_in.mem_wdata | 32'(fb_in.mem_wstrb), 32'h0);
    if (e_mv) check("mem_addr", fb_in.mem_addr, m_pc);

    if (r) begin
      m_q.delete();
      m_pc = RPC; m_idle_next = 1'b0; m_fence_next = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_pc = {ra[31:1], 1'b0};
      m_fence_next = f;
      m_idle_next  = !f;
    end else begin
      accept = e_mv && mr && !m_fence_next;
      if (e_dv && dr) void'(m_q.pop_front());
      if (accept) begin
        comp = (rd[1:0] != 2'b11);
        e.pc = m_pc;
        e.instr = comp ? (rd & 32'h0000_FFFF) : rd;
        e.comp = comp;
        m_q.push_back(e);
        m_pc = m_pc + (comp ? 32'd2 : 32'd4);
      end
      m_idle_next = 1'b0; m_fence_next = 1'b0;
    end
    @(posedge clk);
  endtask

  // Drop flush/reset inputs shortly after an edge so registered state can be inspected
  task automatic quiet();
    #2;
    rst = 1'b0; fence_req = 1'b0; redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] rd, ra;
    rst = 1'b1; fence_req = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
    fb_out.mem_ready = 1'b0; fb_out.mem_rdata = 32'h0; deq_ready = 1'b0;

    step(1, 0, 0, 0, 1, 32'h13, 1);
    step(1, 0, 0, 0, 0, 32'h0, 0);

    // Two 32-bit fetches from reset
    step(0, 0, 0, 0, 1, 32'h0000_0013, 0);
    quiet();
    check("d1_addr", fb_in.mem_addr, 32'h4);
    check("d1_pc", deq_pc, 32'h0);
    check("d1_instr", deq_instr, 32'h13);
    step(0, 0, 0, 0, 1, 32'h0041_0113, 1);
    quiet();
    check("d2_pc", deq_pc, 32'h4);
    check("d2_instr", deq_instr, 32'h0041_0113);

    // Mixed 16/32-bit stream at 0x100
    step(0, 0, 1, 32'h100, 1, 32'h13, 0);
    step(0, 0, 0, 0, 1, 32'h13, 0);
    step(0, 0, 0, 0, 1, 32'h0000_4501, 0);
    quiet();
    check("mix_addr1", fb_in.mem_addr, 32'h102);
    check("mix_instr", deq_instr, 32'h0000_4501);
    check("mix_comp", 32'(deq_comp), 32'h1);
    step(0, 0, 0, 0, 1, 32'hABCD_0513, 1);
    quiet();
    check("mix_addr2", fb_in.mem_addr, 32'h106);

    // Fill to depth, then free one slot
    step(0, 0, 1, 32'h200, 1, 32'h13, 0);
    step(0, 0, 0, 0, 1, 32'h13, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 32'h13, 0);
    quiet();
    check("full_valid", 32'(fb_in.mem_valid), 32'h0);
    step(0, 0, 0, 0, 1, 32'h13, 1);
    quiet();
    check("slot_valid", 32'(fb_in.mem_valid), 32'h1);
    step(0, 0, 0, 0, 1, 32'h13, 0);
    quiet();
    check("refull_valid", 32'(fb_in.mem_valid), 32'h0);

    // Redirect with entries queued and decode ready
    step(0, 0, 1, 32'h2001, 1, 32'h13, 1);
    step(0, 0, 0, 0, 1, 32'h13, 1);
    quiet();
    check("redir_addr", fb_in.mem_addr, 32'h2000);

    // fence.i then a long invalidation stall
    step(0, 1, 0, 32'h80, 1, 32'h13, 1);
    quiet();
    check("fence_flag", 32'(fb_in.mem_fence), 32'h1);
    check("fence_addr", fb_in.mem_addr, 32'h80);
    step(0, 0, 0, 0, 1, 32'h13, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 32'h13, 0);
    step(0, 0, 0, 0, 1, 32'h13, 0);
    quiet();
    check("fence_pc", deq_pc, 32'h80);

    // PC wraps past the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    quiet();
    check("wrap_pre", fb_in.mem_addr, 32'hFFFF_FFFE);
    step(0, 0, 0, 0, 1, 32'h0000_0001, 0);
    quiet();
    check("wrap_addr", fb_in.mem_addr, 32'h0);

    // Reset while in the fence cycle
    step(0, 1, 0, 32'h40, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h13, 1);
    step(1, 0, 0, 0, 1, 32'h13, 1);
    quiet();
    check("rst_fence_addr", fb_in.mem_addr, RPC);
    check("rst_fence_valid", 32'(fb_in.mem_valid), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rd = $urandom;
      if ($urandom_range(1, 0) == 1) rd[1:0] = 2'b11;
      ra = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(($urandom_range(299, 0) == 0), ($urandom_range(39, 0) == 0),
           ($urandom_range(24, 0) == 0), ra,
           ($urandom_range(9, 0) < 7), rd, ($urandom_range(9, 0) < 6));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
